// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle-table write path: beat field layout, FSM encoding, packing helpers.
// No logic of its own; functions are pure and purely combinational.
// Not applicable: carries no handshake.
package rect_pkg;

    // Word 0 layout: {3'h0, en, color, y1, x1}
    localparam int X1_LSB    = 0;
    localparam int X1_W      = 10;
    localparam int Y1_LSB    = 10;
    localparam int Y1_W      = 10;
    localparam int COLOR_LSB = 20;
    localparam int COLOR_W   = 8;
    localparam int EN_BIT    = 28;

    // Word 1 layout: {12'h0, y2, x2}
    localparam int X2_LSB    = 0;
    localparam int X2_W      = 10;
    localparam int Y2_LSB    = 10;
    localparam int Y2_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    function automatic logic [31:0] pack_word0(
        input logic         en,
        input logic [7:0]   color,
        input logic [9:0]   y1,
        input logic [9:0]   x1
    );
        logic [31:0] w;
        w = '0;
        w[X1_LSB    +: X1_W]    = x1;
        w[Y1_LSB    +: Y1_W]    = y1;
        w[COLOR_LSB +: COLOR_W] = color;
        w[EN_BIT]               = en;
        return w;
    endfunction

    function automatic logic [31:0] pack_word1(
        input logic [9:0]   y2,
        input logic [9:0]   x2
    );
        logic [31:0] w;
        w = '0;
        w[X2_LSB +: X2_W] = x2;
        w[Y2_LSB +: Y2_W] = y2;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr+1 (mod N), one-hot out.
// Latency: purely combinational.
// Backpressure: en=0 forces an all-zero grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW:0]  shamt;
    logic [N-1:0] rot;
    logic [N-1:0] pick;

    // Rotate so index ptr+1 lands at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        shamt = {1'b0, ptr} + (PW+1)'(1);
        rot   = N'({req, req} >> shamt);
        pick  = rot & (~rot + N'(1));
        grant = en ? N'(({pick, pick} << shamt) >> N) : '0;
    end

endmodule

// File: rtl/rect_write_arbiter.sv
// Arbitrates NREQ rectangle producers onto the single rect-table write port as atomic 2-beat writes.
// Latency: handshake cycle N, word0 in N+1, word1 in N+2, next grant no earlier than N+3.
// Backpressure: req_ready only in IDLE with wr_hold low; a started pair always completes.
module rect_write_arbiter
    import rect_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int WIDTHBITS  = 10,
    parameter int HEIGHTBITS = 10,
    parameter int COLORBITS  = 8,
    parameter int RECTBITS   = 6
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*RECTBITS-1:0]   req_rect,
    input  logic [NREQ-1:0]            req_en,
    input  logic [NREQ*COLORBITS-1:0]  req_color,
    input  logic [NREQ*WIDTHBITS-1:0]  req_x1,
    input  logic [NREQ*WIDTHBITS-1:0]  req_x2,
    input  logic [NREQ*HEIGHTBITS-1:0] req_y1,
    input  logic [NREQ*HEIGHTBITS-1:0] req_y2,
    input  logic                       wr_hold,
    output logic [31:0]                st__data,
    output logic [RECTBITS:0]          vg__addr,
    output logic                       vg__rect_write,
    output logic                       busy,
    output logic                       err_pulse
);

    localparam int PW = $clog2(NREQ);

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         word1_q, word1_d;
    logic [RECTBITS:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                arb_en;
    logic [NREQ-1:0]     grant;

    logic [PW-1:0]       sel_idx;
    logic [RECTBITS-1:0] sel_rect;
    logic                sel_en;
    logic [COLORBITS-1:0] sel_color;
    logic [WIDTHBITS-1:0] sel_x1, sel_x2;
    logic [HEIGHTBITS-1:0] sel_y1, sel_y2;
    logic                sel_ok;

    assign arb_en = (state_q == ST_IDLE) && !wr_hold;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req   (req_valid),
        .en    (arb_en),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = grant;

    // Steer the granted requester's fields out of the flat buses.
    always_comb begin
        sel_idx   = '0;
        sel_rect  = '0;
        sel_en    = 1'b0;
        sel_color = '0;
        sel_x1    = '0;
        sel_x2    = '0;
        sel_y1    = '0;
        sel_y2    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_idx   = PW'(i);
                sel_rect  = req_rect[i*RECTBITS +: RECTBITS];
                sel_en    = req_en[i];
                sel_color = req_color[i*COLORBITS +: COLORBITS];
                sel_x1    = req_x1[i*WIDTHBITS +: WIDTHBITS];
                sel_x2    = req_x2[i*WIDTHBITS +: WIDTHBITS];
                sel_y1    = req_y1[i*HEIGHTBITS +: HEIGHTBITS];
                sel_y2    = req_y2[i*HEIGHTBITS +: HEIGHTBITS];
            end
        end
    end

    // Bounds check at full port width so out-of-range values are never truncated into range.
    always_comb begin
        sel_ok = (sel_x1 <= sel_x2) && (sel_y1 <= sel_y2) &&
                 (32'(sel_x2) < 32'(WIDTH)) && (32'(sel_y2) < 32'(HEIGHT));
    end

    // Next-state and beat-register loading; beat data is staged one state ahead of its strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        word1_d = word1_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    ptr_d = sel_idx;
                    if (sel_ok) begin
                        state_d = ST_BEAT0;
                        wr_d    = 1'b1;
                        busy_d  = 1'b1;
                        data_d  = pack_word0(sel_en, sel_color, sel_y1, sel_x1);
                        word1_d = pack_word1(sel_y2, sel_x2);
                        addr_d  = {sel_rect, 1'b0};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BEAT0: begin
                state_d = ST_BEAT1;
                wr_d    = 1'b1;
                busy_d  = 1'b1;
                data_d  = word1_q;
                addr_d  = {addr_q[RECTBITS:1], 1'b1};
            end
            ST_BEAT1: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset aborts any pair in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NREQ-1);
            data_q  <= '0;
            word1_q <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            word1_q <= word1_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign st__data       = data_q;
    assign vg__addr       = addr_q;
    assign vg__rect_write = wr_q;
    assign busy           = busy_q;
    assign err_pulse      = err_q;

endmodule
